wb_regfile_sb: RTL
==================

Name: wb_regfile_sb

Overview:
- Parametrised writeback stage for the EX/WB boundary. Owns the architectural register file as clocked state.
- Retires up to two destination writes plus a stack-pointer adjust per cycle, and generates a one-cycle store-writeback pulse.
- Keeps a per-register pending-write scoreboard so decode can detect RAW hazards.
- Provides NRD bypassed read ports to the operand-fetch stage.

Parameters:
- XLEN, 64, register width.
- NREGS, 16, number of architectural registers; index width RW = clog2(NREGS).
- NRD, 2, read/hazard-check ports.
- CNTW, 2, per-register pending-write counter width.
- SP_IDX, 4, index of the stack pointer register.
- SP_RESET, 0, reset value of the stack pointer register.

Ports:
- clk  in  1  clock; all state on posedge.
- reset_n  in  1  asynchronous active-low reset.
- wb_valid  in  1  writeback entry present.
- wb_ready  out  1  stage accepts entry; transfer = wb_valid & wb_ready.
- wb_we0, wb_we1  in  1 each  destination write enables.
- wb_dst0, wb_dst1  in  RW each  destination indices.
- wb_data0, wb_data1  in  XLEN each  result and extended result.
- wb_sp_delta  in  XLEN  signed stack-pointer adjust (two's complement; 0 = none).
- wb_store  in  1  entry completes a store.
- wb_sim_end  in  1  last instruction.
- iss_valid  in  1  decode issues an instruction.
- iss_we0, iss_we1  in  1 each  issued destination enables.
- iss_dst0, iss_dst1  in  RW each  issued destination indices.
- iss_ready  out  1  scoreboard can accept the issue.
- rd_idx  in  NRD*RW  read indices.
- rd_data  out  NRD*XLEN  read data.
- rd_busy  out  NRD  register has pending writes not retiring this cycle.
- store_wb_flag  out  1  store retired pulse.
- sim_done  out  1  simulation end latched.

Behaviour:
- Reset (async assert, sync deassert use):
  - all registers 0 except reg[SP_IDX] = SP_RESET;
  - all counters 0;
  - store_wb_flag = 0, sim_done = 0, wb_ready = 1.
- Retire = wb_valid & wb_ready. On a retire edge, updates apply in this priority order (later wins):
  1. reg[SP_IDX] += wb_sp_delta (mod 2^XLEN);
  2. reg[wb_dst0] = wb_data0 if wb_we0;
  3. reg[wb_dst1] = wb_data1 if wb_we1.
- Consequences of the priority order:
  - wb_dst0 == wb_dst1 with both enabled: dst1 data lands.
  - Explicit write to SP_IDX overrides the delta (pop-into-SP semantics).
- Latency: write visible in the register array the cycle after retire.
- rd_data is combinationally bypassed from the same-cycle retire using the same priority, so rd_data always equals the post-retire value. Bypass of the delta uses reg[SP_IDX] + wb_sp_delta.
- store_wb_flag: registered. It is 1 for exactly the one cycle following a retire with wb_store = 1, otherwise 0; back-to-back stores give consecutive pulses.
- sim_done: set on retire with wb_sim_end = 1, sticky until reset. While sim_done = 1, wb_ready = 0 and no further state changes (including scoreboard).
- Scoreboard, per register r:
  - cnt[r] increments on an issue naming r;
  - cnt[r] decrements on a retire naming r;
  - both in the same cycle: unchanged;
  - an entry naming r in both dst0 and dst1 counts once.
- iss_ready = 0 when any enabled iss_dst has cnt = 2^CNTW-1 and is not being retired this cycle. iss_valid & !iss_ready: no increment.
- Retiring a register with cnt = 0 is a protocol error: cnt stays 0 (no underflow); an assertion fires in simulation.
- rd_busy[k] = (cnt[rd_idx[k]] != 0) and not (cnt = 1 and retiring that index this cycle).
- SP delta alone does not touch the scoreboard. Only wb_we/iss_we destinations count.
- wb_ready = !sim_done; the stage never stalls otherwise.
- Reset mid-operation: all pending counts and in-flight pulses are discarded; outputs return to reset values asynchronously.

Test Plan:
- Reset, then read all regs -> 0 except reg[4] = SP_RESET; rd_busy = 0, store_wb_flag = 0.
- Retire we0 dst=0 data=0xAA, we1 dst=2 data=0xBB; read regs 0 and 2 in the same cycle -> rd_data 0xAA/0xBB via bypass; from the array next cycle.
- SP = 0x1000, retire delta = -8 with wb_store = 1 -> SP = 0x0FF8; store_wb_flag high exactly one cycle. Then retire delta = +8, we0 dst=4 data=0x55 -> SP = 0x55.
- Issue dst=3 three times (CNTW = 2) -> cnt = 3; fourth issue -> iss_ready = 0. Retire dst=3 with simultaneous issue dst=3 -> cnt stays 3. Retire three times -> rd_busy for reg 3 drops in the cycle of the last retire.
- Both ports dst=5, data 1 and 2 -> reg5 = 2, cnt[5] decrements by 1 only.
- Retire with wb_sim_end = 1 -> sim_done = 1, wb_ready = 0; later entries ignored. Assert reset_n = 0 mid-sequence -> immediate reset values.

Source files
------------

// File: rtl/wb_regfile_sb.sv
// Writeback stage: architectural register file, SP adjust, store pulse,
// pending-write scoreboard and bypassed operand read ports.
module wb_regfile_sb #(
    parameter int              XLEN     = 64,
    parameter int              NREGS    = 16,
    parameter int              NRD      = 2,
    parameter int              CNTW     = 2,
    parameter int              SP_IDX   = 4,
    parameter logic [XLEN-1:0] SP_RESET = '0,
    localparam int             RW       = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                wb_valid,
    output logic                wb_ready,
    input  logic                wb_we0,
    input  logic                wb_we1,
    input  logic [RW-1:0]       wb_dst0,
    input  logic [RW-1:0]       wb_dst1,
    input  logic [XLEN-1:0]     wb_data0,
    input  logic [XLEN-1:0]     wb_data1,
    input  logic [XLEN-1:0]     wb_sp_delta,
    input  logic                wb_store,
    input  logic                wb_sim_end,
    input  logic                iss_valid,
    input  logic                iss_we0,
    input  logic                iss_we1,
    input  logic [RW-1:0]       iss_dst0,
    input  logic [RW-1:0]       iss_dst1,
    output logic                iss_ready,
    input  logic [NRD*RW-1:0]   rd_idx,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    output logic                store_wb_flag,
    output logic                sim_done
);

    localparam logic [RW-1:0]   SPI  = RW'(SP_IDX);
    localparam logic [CNTW-1:0] CMAX = '1;
    localparam logic [CNTW-1:0] CONE = CNTW'(1);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic [CNTW-1:0] cnt_q  [NREGS];
    logic [CNTW-1:0] cnt_d  [NREGS];
    logic            store_q;
    logic            done_q;

    logic             retire;
    logic             iss_acc;
    logic             full0;
    logic             full1;
    logic [NREGS-1:0] ret_hit;
    logic [NREGS-1:0] iss_hit;
    logic [NREGS-1:0] underflow;

    assign wb_ready      = !done_q;
    assign retire        = wb_valid & !done_q;
    assign store_wb_flag = store_q;
    assign sim_done      = done_q;

    // Post-retire view: feeds both the array and the bypassed read ports.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            regs_d[r] = regs_q[r];
        end
        if (retire) begin
            regs_d[SPI] = regs_q[SPI] + wb_sp_delta;
            if (wb_we0) regs_d[wb_dst0] = wb_data0;
            if (wb_we1) regs_d[wb_dst1] = wb_data1;
        end
    end

    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            ret_hit[r] = retire & ((wb_we0 & (wb_dst0 == RW'(r))) |
                                   (wb_we1 & (wb_dst1 == RW'(r))));
        end
    end

    assign full0 = iss_we0 & (cnt_q[iss_dst0] == CMAX) & !ret_hit[iss_dst0];
    assign full1 = iss_we1 & (cnt_q[iss_dst1] == CMAX) & !ret_hit[iss_dst1];
    assign iss_ready = !(full0 | full1);
    assign iss_acc   = iss_valid & iss_ready & !done_q;

    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            iss_hit[r]   = iss_acc & ((iss_we0 & (iss_dst0 == RW'(r))) |
                                      (iss_we1 & (iss_dst1 == RW'(r))));
            underflow[r] = ret_hit[r] & (cnt_q[r] == '0);
            cnt_d[r]     = cnt_q[r];
            if (iss_hit[r] && !ret_hit[r]) begin
                cnt_d[r] = cnt_q[r] + CONE;
            end else if (ret_hit[r] && !iss_hit[r] && !underflow[r]) begin
                cnt_d[r] = cnt_q[r] - CONE;
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [RW-1:0] idx;
        assign idx = rd_idx[k*RW +: RW];
        assign rd_data[k*XLEN +: XLEN] = regs_d[idx];
        assign rd_busy[k] = (cnt_q[idx] != '0) &&
                            !((cnt_q[idx] == CONE) && ret_hit[idx]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= (r == SP_IDX) ? SP_RESET : '0;
                cnt_q[r]  <= '0;
            end
            store_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= regs_d[r];
                cnt_q[r]  <= cnt_d[r];
            end
            store_q <= retire & wb_store;
            if (retire && wb_sim_end) done_q <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    // Retiring a register with no pending write means decode lost track.
    a_no_underflow: assert property (
        @(posedge clk) disable iff (!reset_n) underflow == '0
    );
`endif

endmodule
